div: RTL and testbench

- Multi-cycle 32-bit integer divider for the MIPS datapath, serving DIV/DIVU.
- Reset starts each operation. The block then iterates one quotient bit per clock (restoring algorithm).
- Quotient and remainder are held stable once done is high, until the next reset.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_if.sv | 16 +
 rtl/div_abs.sv | 12 +
 rtl/div.sv | 96 +++++++++
 tb/tb_div.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the multi-cycle restoring divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int CNT_W = cnt_w(DIV_WIDTH);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/div_if.sv
// Operand/result bundle between the datapath sequencer (master) and the divider (slave).
interface div_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signdiv;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             done;

   modport master (output a, b, signdiv, input q, r, done);
   modport slave  (input a, b, signdiv, output q, r, done);
endinterface

// File: rtl/div_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module div_abs
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);
   assign y = neg ? -x : x;
endmodule

// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU; one quotient bit per clock, results held until reset.
//   state  | meaning
//   S_LOAD | capture operand magnitudes, sign flags and div-by-zero flag
//   S_RUN  | one shift/trial-subtract step per edge, WIDTH steps
//   S_FIX  | apply result signs, register q/r, raise done
//   S_DONE | hold results; only divrst leaves this state
module div
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input logic clk,
   input logic divrst,
   div_if.slave bus
);
   localparam int CW = cnt_w(WIDTH);

   div_state_t       state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, dvd, dvs, qsr, a_raw;
   logic             neg_q, neg_r, dz;
   logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix, diff;
   logic [WIDTH:0]   part;
   logic             ge;

   div_abs #(.WIDTH(WIDTH)) u_abs_a (.x(bus.a), .neg(bus.signdiv & bus.a[WIDTH-1]), .y(a_mag));
   div_abs #(.WIDTH(WIDTH)) u_abs_b (.x(bus.b), .neg(bus.signdiv & bus.b[WIDTH-1]), .y(b_mag));
   div_abs #(.WIDTH(WIDTH)) u_fix_q (.x(qsr),   .neg(neg_q),                        .y(q_fix));
   div_abs #(.WIDTH(WIDTH)) u_fix_r (.x(rem),   .neg(neg_r),                        .y(r_fix));

   // Partial remainder is one bit wider than the divisor after the shift; when the
   // trial succeeds the true difference is below the divisor, so the low bits suffice.
   assign part = {rem, dvd[WIDTH-1]};
   assign ge   = (part >= {1'b0, dvs});
   assign diff = part[WIDTH-1:0] - dvs;

   always_ff @(posedge clk or posedge divrst) begin
      if (divrst) state <= S_LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD: state_nxt = S_RUN;
         S_RUN:  if (cnt == CW'(1)) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: state_nxt = S_DONE;
         default: state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge divrst) begin
      if (divrst) begin
         cnt      <= '0;
         rem      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         qsr      <= '0;
         a_raw    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz       <= 1'b0;
         bus.q    <= '0;
         bus.r    <= '0;
         bus.done <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               dvd   <= a_mag;
               dvs   <= b_mag;
               rem   <= '0;
               qsr   <= '0;
               a_raw <= bus.a;
               neg_q <= bus.signdiv & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               neg_r <= bus.signdiv & bus.a[WIDTH-1];
               dz    <= (bus.b == '0);
               cnt   <= CW'(WIDTH);
            end
            S_RUN: begin
               dvd <= {dvd[WIDTH-2:0], 1'b0};
               rem <= ge ? diff : part[WIDTH-1:0];
               qsr <= {qsr[WIDTH-2:0], ge};
               cnt <= cnt - CW'(1);
            end
            S_FIX: begin
               // Divide-by-zero bypasses sign fix-up: all-ones quotient, raw dividend remainder.
               bus.q    <= dz ? '1 : q_fix;
               bus.r    <= dz ? a_raw : r_fix;
               bus.done <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized operands vs an arithmetic model.
module tb_div;
   import div_pkg::*;

   logic clk;
   logic divrst;
   int   n_cmp;
   int   n_bad;

   div_if #(.WIDTH(32)) bus ();

   div #(.WIDTH(32)) dut (
      .clk    (clk),
      .divrst (divrst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic in 64 bits so -2^31 / -1 wraps to 0x80000000.
   function automatic void model(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                                 output logic [31:0] qe, output logic [31:0] re);
      longint na, nb;
      if (bv == 32'd0) begin
         qe = 32'hFFFFFFFF;
         re = av;
      end else if (sv) begin
         na = longint'($signed(av));
         nb = longint'($signed(bv));
         qe = 32'(na / nb);
         re = 32'(na % nb);
      end else begin
         na = longint'({32'd0, av});
         nb = longint'({32'd0, bv});
         qe = 32'(na / nb);
         re = 32'(na % nb);
      end
   endfunction

   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv, input string tag);
      int          edges;
      logic        early;
      logic [31:0] qe, re;
      model(av, bv, sv, qe, re);
      @(negedge clk);
      bus.a = av; bus.b = bv; bus.signdiv = sv;
      divrst = 1'b1;
      @(negedge clk);
      divrst = 1'b0;
      edges = 0;
      early = 1'b0;
      while (edges < 40 && bus.done !== 1'b1) begin
         @(posedge clk);
         #1;
         edges++;
         if (bus.done !== 1'b1 && (bus.q !== 32'd0 || bus.r !== 32'd0)) early = 1'b1;
         if (edges == 1) begin
            bus.a = $urandom; bus.b = $urandom; bus.signdiv = 1'($urandom);
         end
      end
      chk($sformatf("%s_latency", tag), 32'(edges), 32'd34);
      chk($sformatf("%s_early_zero", tag), {31'd0, early}, 32'd0);
      chk($sformatf("%s_q", tag), bus.q, qe);
      chk($sformatf("%s_r", tag), bus.r, re);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("%s_q_hold", tag), bus.q, qe);
      chk($sformatf("%s_r_hold", tag), bus.r, re);
      chk($sformatf("%s_done_hold", tag), {31'd0, bus.done}, 32'd1);
   endtask

   initial begin
      logic [31:0] ra, rb;
      n_cmp = 0;
      n_bad = 0;
      divrst = 1'b1;
      bus.a = '0; bus.b = '0; bus.signdiv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_q", bus.q, 32'd0);
      chk("reset_r", bus.r, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);

      run_op(32'd9,          32'd2,          1'b0, "u_9_2");
      run_op(32'hFFFFFFF7,   32'd2,          1'b1, "s_m9_2");
      run_op(32'd9,          32'hFFFFFFFE,   1'b1, "s_9_m2");
      run_op(32'hFFFFFFFF,   32'd1,          1'b0, "u_max_1");
      run_op(32'hFFFFFFFF,   32'd1,          1'b1, "s_m1_1");
      run_op(32'h12345678,   32'd0,          1'b0, "u_dz");
      run_op(32'h12345678,   32'd0,          1'b1, "s_dz");
      run_op(32'h80000000,   32'hFFFFFFFF,   1'b1, "s_ovf");

      // Reset landing between edges while results are held must clear them at once.
      #3 divrst = 1'b1;
      #1;
      chk("rst_done_q", bus.q, 32'd0);
      chk("rst_done_r", bus.r, 32'd0);
      chk("rst_done_done", {31'd0, bus.done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_held_q", bus.q, 32'd0);
      chk("rst_held_done", {31'd0, bus.done}, 32'd0);

      // Abort ten steps into RUN, then restart a fresh division.
      @(negedge clk);
      bus.a = 32'hDEADBEEF; bus.b = 32'd3; bus.signdiv = 1'b0;
      divrst = 1'b0;
      repeat (11) @(posedge clk);
      #3 divrst = 1'b1;
      #1;
      chk("rst_mid_q", bus.q, 32'd0);
      chk("rst_mid_r", bus.r, 32'd0);
      chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
      run_op(32'd100, 32'd7, 1'b0, "restart_100_7");

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom;
            1:       rb = 32'($urandom_range(1, 255));
            2:       rb = -32'($urandom_range(1, 255));
            default: rb = (i % 7 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
         endcase
         run_op(ra, rb, 1'($urandom), $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
